sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; requester 0 is the pixel pipeline.
REQ-002 Parameter ADDR_W, default 17: sprite ROM address width.
REQ-003 Parameter DATA_W, default 8: ROM word width (palette index).
REQ-004 Parameter RD_LAT, default 1: cycles from rom_rd/rom_addr to valid rom_q, range 1..4.
REQ-005 Parameter STARVE_MAX, default 15: max cycles a pending requester 1..N-1 waits while requester 0 wins.
REQ-006 vga_clk  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NUM_REQ  per-requester read request, held until granted.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  packed addresses, slice i belongs to req[i], stable while req[i] high.
REQ-010 gnt  output  NUM_REQ  one-hot grant, combinational; request accepted when req[i]&gnt[i].
REQ-011 rom_rd  output  1  registered ROM read strobe.
REQ-012 rom_addr  output  ADDR_W  registered ROM address.
REQ-013 rom_q  input  DATA_W  ROM read data, valid RD_LAT cycles after rom_rd.
REQ-014 rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-015 rsp_data  output  DATA_W  response data, qualified by rsp_valid.

Function
REQ-016 gnt SHALL be at most one-hot and zero when req is zero.
REQ-017 Default: req[0] wins whenever asserted.
REQ-018 Otherwise round-robin among 1..NUM_REQ-1, search starting at rr_ptr; after grant to k>=1, rr_ptr = next index after k, wrapping NUM_REQ-1 -> 1.
REQ-019 starve_cnt increments each cycle a requester in 1..N-1 is pending and not granted; clears on any grant to 1..N-1 or when none pending; saturates at STARVE_MAX.
REQ-020 When starve_cnt == STARVE_MAX, the round-robin winner SHALL be granted even if req[0] is high.
REQ-021 On acceptance of requester i, next cycle: rom_rd=1, rom_addr=req_addr slice i; else rom_rd=0, rom_addr holds.
REQ-022 Owner ID SHALL travel a RD_LAT-deep shift pipeline alongside rom_rd; rsp_valid[i]=1 and rsp_data=rom_q exactly RD_LAT cycles after rom_rd (total latency RD_LAT+1 from acceptance).
REQ-023 Throughput one acceptance per cycle; back-to-back grants to any mix of requesters SHALL return in acceptance order without loss.
REQ-024 rsp_data SHALL hold its last value when rsp_valid is zero.
REQ-025 Request deasserted before grant: no access issued, no state change beyond starve_cnt/rr_ptr rules.

Reset
REQ-026 While reset_n low: gnt=0, rom_rd=0, rom_addr=0, rsp_valid=0, rsp_data=0, rr_ptr=1, starve_cnt=0, owner pipeline cleared.
REQ-027 Reset mid-transaction SHALL discard in-flight reads; no rsp_valid after release for pre-reset acceptances.
REQ-028 First grant possible in the first rising edge after reset_n deasserts.

Structure
REQ-029 Package sprite_arb_pkg SHALL hold default NUM_REQ, ADDR_W, DATA_W, RD_LAT, STARVE_MAX constants and the owner-ID width function.
REQ-030 Round-robin search SHALL be a sub-module rr_picker (req vector, pointer in; one-hot winner, valid out).

Verification
REQ-031 Only req[2]=1, addr 0x00123 -> gnt=0100 same cycle; rom_addr=0x00123 next cycle; rsp_valid=0100 with rom_q after RD_LAT more.
REQ-032 req=1110 held 6 cycles, rr_ptr=1 -> grant order 1,2,3,1,2,3; responses in same order.
REQ-033 req[0] held high, req[1] high, STARVE_MAX=15 -> requester 0 granted 15 cycles, requester 1 granted on cycle 16, starve_cnt then 0.
REQ-034 Alternating acceptances 0,3,0,3 every cycle, RD_LAT=3 -> four rsp_valid pulses, consecutive, owners 0,3,0,3, data matching addresses.
REQ-035 Assert reset_n low one cycle after two acceptances -> all outputs zero immediately; no rsp_valid after release until new acceptance.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared defaults and helpers for the sprite ROM arbiter
package sprite_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_STARVE_MAX = 15;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester, ROM and response signals of the sprite ROM arbiter
interface sprite_rom_arbiter_if
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rom_rd;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req, req_addr, rom_q,
        input  gnt, rom_rd, rom_addr, rsp_valid, rsp_data
    );

    modport slave (
        input  req, req_addr, rom_q,
        output gnt, rom_rd, rom_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// rtl/sprite_rom_arbiter_rr_picker.sv - round-robin search over requesters 1..NUM_REQ-1
module rr_picker
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W   = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [ID_W-1:0] idx;

    // Index 0 never participates; the search wraps NUM_REQ-1 back to 1.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int off = 0; off < NUM_REQ - 1; off++) begin
            idx = ID_W'(((int'(ptr) - 1 + off) % (NUM_REQ - 1)) + 1);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - priority/round-robin arbiter sharing one sprite ROM
// Requester 0 (pixel pipeline) wins unless another requester has starved for STARVE_MAX cycles.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic           vga_clk,
    input  logic           reset_n,
    sprite_rom_arbiter_if.slave bus
);

    localparam int ID_W = owner_w(NUM_REQ);
    localparam int SW   = $clog2(STARVE_MAX + 1);

    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_win;
    logic               rr_valid;
    logic [ID_W-1:0]    rr_ptr;
    logic [SW-1:0]      starve_cnt;
    logic               starved;

    logic [NUM_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]    gnt_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic               accept;
    logic               gnt_low_prio;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic [RD_LAT:0]    own_v;
    logic [ID_W-1:0]    own_id [RD_LAT+1];
    logic [DATA_W-1:0]  data_hold;

    assign rr_req  = {bus.req[NUM_REQ-1:1], 1'b0};
    assign starved = (starve_cnt == SW'(STARVE_MAX));

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req    (rr_req),
        .ptr    (rr_ptr),
        .winner (rr_win),
        .valid  (rr_valid)
    );

    always_comb begin
        gnt_vec = '0;
        if (!reset_n) begin
            gnt_vec = '0;
        end else if (rr_valid && (starved || !bus.req[0])) begin
            gnt_vec = rr_win;
        end else if (bus.req[0]) begin
            gnt_vec = NUM_REQ'(1);
        end
    end

    always_comb begin
        gnt_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                gnt_id   = ID_W'(i);
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign accept       = |(bus.req & gnt_vec);
    assign gnt_low_prio = accept && (gnt_id != '0);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= ID_W'(1);
            starve_cnt <= '0;
            rom_addr_q <= '0;
            own_v      <= '0;
            data_hold  <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                own_id[k] <= '0;
            end
        end else begin
            if (gnt_low_prio) begin
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : gnt_id + ID_W'(1);
            end
            if (gnt_low_prio || !rr_valid) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (accept) begin
                rom_addr_q <= sel_addr;
            end
            // Stage 0 is the rom_rd cycle; stage RD_LAT lines up with rom_q.
            own_v     <= {own_v[RD_LAT-1:0], accept};
            own_id[0] <= gnt_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                own_id[k] <= own_id[k-1];
            end
            data_hold <= bus.rsp_data;
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.rom_rd    = own_v[0];
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = own_v[RD_LAT] ? (NUM_REQ'(1) << own_id[RD_LAT]) : '0;
    assign bus.rsp_data  = own_v[RD_LAT] ? bus.rom_q : data_hold;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed scoreboard bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 3;
    localparam int SMAX    = 15;

    typedef struct {
        int               due;
        int               id;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    int   cyc;
    ent_t sb [$];
    logic [ADDR_W-1:0] addr [NUM_REQ];
    logic              exp_rd;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] rom_pipe [1:RD_LAT];

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[16:9] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        rom_pipe[1] <= rom_f(bus.rom_addr);
        for (int k = 2; k <= RD_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign bus.rom_q = rom_pipe[RD_LAT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] eg);
        ent_t e;
        int   id;
        bus.req      = r;
        bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
        @(negedge clk);
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("rom_rd", 32'(bus.rom_rd), 32'(exp_rd));
        if (exp_rd) check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        if (bus.rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rsp_spurious", 32'(bus.rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 32'(bus.rsp_valid), 32'(4'b0001 << e.id));
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                check("rsp_latency", 32'(cyc), 32'(e.due));
                last_data = e.data;
            end
        end else begin
            check("rsp_hold", 32'(bus.rsp_data), 32'(last_data));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rsp_missing", 32'(bus.rsp_valid), 32'(4'b0001 << e.id));
            end
        end
        exp_rd = |(r & eg);
        if (exp_rd) begin
            id = 0;
            for (int i = 0; i < NUM_REQ; i++) if (eg[i]) id = i;
            exp_addr = addr[id];
            e.due    = cyc + RD_LAT + 1;
            e.id     = id;
            e.data   = rom_f(addr[id]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rom_rd", 32'(bus.rom_rd), 32'h0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        exp_rd     = 1'b0;
        exp_addr   = '0;
        last_data  = '0;
        addr[0] = 17'h00A10;
        addr[1] = 17'h1F0C3;
        addr[2] = 17'h00123;
        addr[3] = 17'h0BEEF;
        bus.req      = 4'b0100;
        bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Round robin from rr_ptr=1 with requester 0 idle
        for (int i = 0; i < 6; i++) cycle(4'b1110, 4'b0010 << (i % 3));

        // Single request from requester 2
        cycle(4'b0100, 4'b0100);
        repeat (RD_LAT + 3) cycle(4'b0000, 4'b0000);

        // Interleaved 0,3,0,3 with changing addresses
        for (int i = 0; i < 4; i++) begin
            addr[0] = 17'h00200 + 17'(i * 17);
            addr[3] = 17'h12000 + 17'(i * 33);
            if (i % 2 == 0) cycle(4'b0001, 4'b0001);
            else            cycle(4'b1000, 4'b1000);
        end
        repeat (RD_LAT + 3) cycle(4'b0000, 4'b0000);

        // Starvation: requester 1 wins after SMAX grants to requester 0
        for (int i = 0; i < SMAX; i++) cycle(4'b0011, 4'b0001);
        cycle(4'b0011, 4'b0010);
        // Counter restarts from zero after the forced grant
        for (int i = 0; i < 5; i++) cycle(4'b0011, 4'b0001);
        // Request withdrawn before grant clears the counter
        cycle(4'b0001, 4'b0001);
        for (int i = 0; i < SMAX; i++) cycle(4'b0011, 4'b0001);
        cycle(4'b0011, 4'b0010);
        repeat (RD_LAT + 3) cycle(4'b0000, 4'b0000);
        check("sb_drained_1", 32'(sb.size()), 32'h0);

        // Reset with two reads in flight
        cycle(4'b0001, 4'b0001);
        cycle(4'b0100, 4'b0100);
        bus.req = 4'b0100;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        exp_rd    = 1'b0;
        last_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (RD_LAT + 3) cycle(4'b0000, 4'b0000);
        // rr_ptr back at 1 selects requester 2 ahead of 3
        cycle(4'b1100, 4'b0100);
        repeat (RD_LAT + 3) cycle(4'b0000, 4'b0000);
        check("sb_drained_2", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
